// File: rtl/fpu_regfile_pkg.sv
// Shared types and helpers for the FPU master register file.
// Build option: define FPU_REGFILE_BYPASS_EN for new-data read-during-write.
package fpu_regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Address width for a given entry count; never narrower than one bit.
    function automatic int unsigned aw_of(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fpu_master_regfile_if.sv
// Access bus of the FPU master register file: one write port, two read ports, busy flag.
interface fpu_master_regfile_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
);
    import fpu_regfile_pkg::*;

    localparam int unsigned AW = aw_of(DEPTH);

    logic             WREN;
    logic [AW-1:0]    WADDR;
    logic [WIDTH-1:0] DI;
    logic             RDENA;
    logic [AW-1:0]    RADDRA;
    logic             RDENB;
    logic [AW-1:0]    RADDRB;
    logic [WIDTH-1:0] DOA;
    logic [WIDTH-1:0] DOB;
    logic             BUSY;

    modport master (
        output WREN, WADDR, DI, RDENA, RADDRA, RDENB, RADDRB,
        input  DOA, DOB, BUSY
    );

    modport slave (
        input  WREN, WADDR, DI, RDENA, RADDRA, RDENB, RADDRB,
        output DOA, DOB, BUSY
    );

endinterface

// File: rtl/fpu_regfile_rdport.sv
// One registered read port: address range check, optional write bypass, hold when idle.
// Build option: FPU_REGFILE_BYPASS_EN selects new data on a same-address write.
module fpu_regfile_rdport
    import fpu_regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = aw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] rdata,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] dout
);

    logic             in_range_c;
    logic [WIDTH-1:0] next_c;

    assign in_range_c = ({1'b0, addr} < (AW+1)'(DEPTH));

`ifdef FPU_REGFILE_BYPASS_EN
    // Same-cycle write to the read address forwards the incoming data.
    always_comb begin
        next_c = '0;
        if (in_range_c) begin
            next_c = (wr_en && (wr_addr == addr)) ? wr_data : rdata;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data};

    // Old contents are returned; out-of-range reads return zero.
    always_comb begin
        next_c = '0;
        if (in_range_c) begin
            next_c = rdata;
        end
    end
`endif

    // Output register: loads on enable, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= next_c;
        end
    end

endmodule

// File: rtl/fpu_master_regfile.sv
// FPU master register file: init sweep after reset, one write port, two registered read ports.
// Build option: FPU_REGFILE_BYPASS_EN (read-during-write returns new data).
module fpu_master_regfile
    import fpu_regfile_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned     AW         = aw_of(DEPTH)
) (
    input logic                 CLK,
    input logic                 RESET,
    fpu_master_regfile_if.slave bus
);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             run_c;
    logic             wr_ok_c;
    logic [WIDTH-1:0] doa, dob;
    logic [WIDTH-1:0] mem [DEPTH];

    assign run_c   = (state_q == ST_RUN);
    assign wr_ok_c = run_c && bus.WREN && ({1'b0, bus.WADDR} < (AW+1)'(DEPTH));

    // State, sweep counter and busy flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Sweep sequencing: walk every entry once, then serve accesses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    // Storage: sweep writes during init, bus writes during run; reset leaves contents.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q] <= INIT_VALUE;
            end else if (wr_ok_c) begin
                mem[bus.WADDR] <= bus.DI;
            end
        end
    end

    fpu_regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_a (
        .clk     (CLK),
        .rst     (RESET),
        .en      (run_c && bus.RDENA),
        .addr    (bus.RADDRA),
        .rdata   (mem[bus.RADDRA]),
        .wr_en   (wr_ok_c),
        .wr_addr (bus.WADDR),
        .wr_data (bus.DI),
        .dout    (doa)
    );

    fpu_regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_b (
        .clk     (CLK),
        .rst     (RESET),
        .en      (run_c && bus.RDENB),
        .addr    (bus.RADDRB),
        .rdata   (mem[bus.RADDRB]),
        .wr_en   (wr_ok_c),
        .wr_addr (bus.WADDR),
        .wr_data (bus.DI),
        .dout    (dob)
    );

    assign bus.DOA  = doa;
    assign bus.DOB  = dob;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_fpu_master_regfile.sv
// Scoreboard bench for fpu_master_regfile: a 16-entry and a 12-entry instance
// driven side by side against a behavioural model of the register file.
module tb_fpu_master_regfile;

    localparam logic [31:0] INIT0 = 32'hDEAD_BEEF;
    localparam logic [31:0] INIT1 = 32'h0BAD_F00D;
    localparam bit BYP =
`ifdef FPU_REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    fpu_master_regfile_if #(.WIDTH(32), .DEPTH(16)) bus0 ();
    fpu_master_regfile_if #(.WIDTH(32), .DEPTH(12)) bus1 ();

    fpu_master_regfile #(.WIDTH(32), .DEPTH(16), .INIT_VALUE(INIT0)) dut0 (
        .CLK(clk), .RESET(rst0), .bus(bus0.slave));
    fpu_master_regfile #(.WIDTH(32), .DEPTH(12), .INIT_VALUE(INIT1)) dut1 (
        .CLK(clk), .RESET(rst1), .bus(bus1.slave));

    typedef struct {
        bit          rst;
        bit          wen;
        int unsigned waddr;
        logic [31:0] di;
        bit          rena;
        int unsigned ra;
        bit          renb;
        int unsigned rb;
    } in_t;

    typedef struct {
        int unsigned tag;
        int          dut;
        logic [31:0] doa;
        logic [31:0] dob;
        bit          busy;
    } exp_t;

    exp_t        sbq[$];
    in_t         inp [2];
    logic [31:0] ref_mem [2][16];
    int unsigned ref_left [2];
    logic [31:0] ref_doa [2];
    logic [31:0] ref_dob [2];
    int unsigned depth_of [2] = '{16, 12};
    logic [31:0] init_of [2] = '{INIT0, INIT1};
    int unsigned edges = 0;
    int compared = 0;
    int mismatched = 0;

    always @(posedge clk) edges++;

    function automatic in_t idle_in();
        in_t x;
        x.rst = 1'b0; x.wen = 1'b0; x.waddr = 0; x.di = '0;
        x.rena = 1'b0; x.ra = 0; x.renb = 1'b0; x.rb = 0;
        return x;
    endfunction

    function automatic logic [31:0] ref_read(input int d, input int unsigned a, input in_t x);
        if (a >= depth_of[d]) return '0;
        if (BYP && x.wen && x.waddr == a) return x.di;
        return ref_mem[d][a];
    endfunction

    task automatic compare(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d edge %0d: got %h, expected %h", name, d, edges, got, exp);
        end
    endtask

    // Monitor: compare every expected snapshot due after the latest clock edge.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].tag <= edges) begin
            e = sbq.pop_front();
            if (e.tag != edges) begin
                compared++;
                mismatched++;
                $display("FAIL stale_entry dut%0d: tag %0d, now %0d", e.dut, e.tag, edges);
            end else if (e.dut == 0) begin
                compare("doa", 0, bus0.DOA, e.doa);
                compare("dob", 0, bus0.DOB, e.dob);
                compare("busy", 0, 32'(bus0.BUSY), 32'(e.busy));
            end else begin
                compare("doa", 1, bus1.DOA, e.doa);
                compare("dob", 1, bus1.DOB, e.dob);
                compare("busy", 1, 32'(bus1.BUSY), 32'(e.busy));
            end
        end
    end

    // Apply one cycle of stimulus to both instances and record the expected outcome.
    task automatic step();
        exp_t e;
        logic [31:0] na, nb;
        @(negedge clk);
        rst0 = inp[0].rst;
        bus0.WREN = inp[0].wen;   bus0.WADDR = 4'(inp[0].waddr); bus0.DI = inp[0].di;
        bus0.RDENA = inp[0].rena; bus0.RADDRA = 4'(inp[0].ra);
        bus0.RDENB = inp[0].renb; bus0.RADDRB = 4'(inp[0].rb);
        rst1 = inp[1].rst;
        bus1.WREN = inp[1].wen;   bus1.WADDR = 4'(inp[1].waddr); bus1.DI = inp[1].di;
        bus1.RDENA = inp[1].rena; bus1.RADDRA = 4'(inp[1].ra);
        bus1.RDENB = inp[1].renb; bus1.RADDRB = 4'(inp[1].rb);
        for (int d = 0; d < 2; d++) begin
            if (inp[d].rst) begin
                ref_left[d] = depth_of[d];
                ref_doa[d] = '0;
                ref_dob[d] = '0;
            end else if (ref_left[d] > 0) begin
                ref_mem[d][depth_of[d] - ref_left[d]] = init_of[d];
                ref_left[d]--;
            end else begin
                na = inp[d].rena ? ref_read(d, inp[d].ra, inp[d]) : ref_doa[d];
                nb = inp[d].renb ? ref_read(d, inp[d].rb, inp[d]) : ref_dob[d];
                if (inp[d].wen && inp[d].waddr < depth_of[d]) ref_mem[d][inp[d].waddr] = inp[d].di;
                ref_doa[d] = na;
                ref_dob[d] = nb;
            end
            e.tag = edges + 1;
            e.dut = d;
            e.doa = ref_doa[d];
            e.dob = ref_dob[d];
            e.busy = (ref_left[d] > 0);
            sbq.push_back(e);
        end
    endtask

    task automatic rand_in(input int d, input bit allow_rst);
        inp[d] = idle_in();
        inp[d].rst = allow_rst && ($urandom_range(0, 79) == 0);
        inp[d].wen = $urandom_range(0, 1) == 1;
        inp[d].waddr = $urandom_range(0, 15);
        inp[d].di = $urandom;
        inp[d].rena = $urandom_range(0, 2) != 0;
        inp[d].ra = ($urandom_range(0, 3) == 0) ? inp[d].waddr : $urandom_range(0, 15);
        inp[d].renb = $urandom_range(0, 2) != 0;
        inp[d].rb = ($urandom_range(0, 3) == 0) ? inp[d].waddr : $urandom_range(0, 15);
    endtask

    initial begin
        bus0.WREN = 0; bus0.WADDR = '0; bus0.DI = '0; bus0.RDENA = 0; bus0.RADDRA = '0; bus0.RDENB = 0; bus0.RADDRB = '0;
        bus1.WREN = 0; bus1.WADDR = '0; bus1.DI = '0; bus1.RDENA = 0; bus1.RADDRA = '0; bus1.RDENB = 0; bus1.RADDRB = '0;

        // Reset pulse, then the sweep with ignored traffic on the 16-entry instance.
        inp[0] = idle_in(); inp[1] = idle_in();
        inp[0].rst = 1; inp[1].rst = 1;
        step(); step();
        inp[1] = idle_in();
        for (int i = 0; i < 16; i++) begin
            rand_in(0, 1'b0);
            step();
        end

        // Read back every entry on both ports.
        for (int i = 0; i < 16; i++) begin
            inp[0] = idle_in(); inp[1] = idle_in();
            inp[0].rena = 1; inp[0].ra = i; inp[0].renb = 1; inp[0].rb = 15 - i;
            inp[1].rena = 1; inp[1].ra = i % 12; inp[1].renb = 1; inp[1].rb = 11 - (i % 12);
            step();
        end

        // Write entry 5, then read 5 on A and 0 on B.
        inp[0] = idle_in(); inp[1] = idle_in();
        inp[0].wen = 1; inp[0].waddr = 5; inp[0].di = 32'h1234;
        step();
        inp[0] = idle_in();
        inp[0].rena = 1; inp[0].ra = 5; inp[0].renb = 1; inp[0].rb = 0;
        step();

        // Read-during-write on entry 3, then a plain read.
        inp[0] = idle_in();
        inp[0].wen = 1; inp[0].waddr = 3; inp[0].di = 32'hAAAA; inp[0].rena = 1; inp[0].ra = 3;
        step();
        inp[0] = idle_in();
        inp[0].rena = 1; inp[0].ra = 3;
        step();

        // Out-of-range write and read on the 12-entry instance, then entries 0..11.
        inp[0] = idle_in(); inp[1] = idle_in();
        inp[1].wen = 1; inp[1].waddr = 13; inp[1].di = 32'h55;
        step();
        inp[1] = idle_in();
        inp[1].rena = 1; inp[1].ra = 13; inp[1].renb = 1; inp[1].rb = 12;
        step();
        for (int i = 0; i < 12; i++) begin
            inp[1] = idle_in();
            inp[1].rena = 1; inp[1].ra = i;
            step();
        end

        // Port A holds while its last-read entry is rewritten.
        inp[1] = idle_in();
        inp[0] = idle_in(); inp[0].rena = 1; inp[0].ra = 5;
        step();
        for (int i = 0; i < 10; i++) begin
            inp[0] = idle_in();
            inp[0].wen = 1; inp[0].waddr = 5; inp[0].di = $urandom;
            inp[0].renb = 1; inp[0].rb = $urandom_range(0, 15);
            step();
        end

        // Reset in the middle of the sweep restarts it.
        inp[0] = idle_in(); inp[0].rst = 1;
        step();
        for (int i = 0; i < 7; i++) begin
            rand_in(0, 1'b0);
            step();
        end
        inp[0] = idle_in(); inp[0].rst = 1;
        step();
        for (int i = 0; i < 18; i++) begin
            rand_in(0, 1'b0);
            step();
        end

        // Random traffic with occasional resets on both instances.
        for (int i = 0; i < 400; i++) begin
            rand_in(0, 1'b1);
            rand_in(1, 1'b1);
            step();
        end

        inp[0] = idle_in(); inp[1] = idle_in();
        step();
        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_master_regfile.md
FPU_MASTER_REGFILE -- requirements
Module: fpu_master_regfile

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, 1..128.
REQ-002 Parameter DEPTH, default 16: number of entries, 2..256, not necessarily a power of two.
REQ-003 Parameter INIT_VALUE, default 0 (WIDTH bits): value written to every entry by the init sweep.
REQ-004 Derived constant AW = $clog2(DEPTH): address width.
REQ-005 CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-007 WREN  input  1  write enable.
REQ-008 WADDR  input  AW  write address.
REQ-009 DI  input  WIDTH  write data.
REQ-010 RDENA / RDENB  input  1 each  read enable, port A / port B.
REQ-011 RADDRA / RADDRB  input  AW each  read address, port A / port B.
REQ-012 DOA / DOB  output  WIDTH each  registered read data, port A / port B.
REQ-013 BUSY  output  1  high while the init sweep runs; all accesses are ignored while high.

Function
REQ-014 Two-state FSM, INIT and RUN; reset enters INIT with sweep counter = 0.
REQ-015 INIT: each cycle writes INIT_VALUE to entry[counter] and increments counter; at counter = DEPTH-1 the write completes and the next state is RUN.
REQ-016 Sweep takes exactly DEPTH cycles after RESET deasserts; BUSY is low from cycle DEPTH+1 onward.
REQ-017 In INIT, WREN, RDENA and RDENB are ignored, and DOA/DOB hold their values.
REQ-018 RUN: when WREN=1 and WADDR < DEPTH, entry[WADDR] <= DI at the clock edge.
REQ-019 RUN: when RDENx=1, DOx <= entry[RADDRx] at the clock edge, giving one-cycle read latency; when RDENx=0, DOx holds.
REQ-020 Reads with RADDRx >= DEPTH return 0; writes with WADDR >= DEPTH are dropped.
REQ-021 Both read ports are independent: the same or different addresses on the same cycle are both served.
REQ-022 Read-during-write to the same address on the same cycle follows REQ-028/REQ-029.

Reset
REQ-023 RESET=1 forces state INIT, counter 0, DOA = DOB = 0, and BUSY = 1 on the following cycle.
REQ-024 Reset in the middle of the sweep or during RUN restarts the full sweep; array contents are not otherwise cleared by RESET itself.
REQ-025 RESET takes priority over every other input on the same edge.

Configuration
REQ-026 Macro FPU_REGFILE_BYPASS_EN selects read-during-write behaviour.
REQ-027 The macro affects no other behaviour.
REQ-028 Macro defined: a RUN read of address X with a same-cycle write to X returns DI (new data) on DOx, on each port independently.
REQ-029 Macro undefined: the same case returns the old entry contents; the write still takes effect.

Structure
REQ-030 Package fpu_regfile_pkg holds the state enum (INIT, RUN) and a function that computes AW from DEPTH.
REQ-031 A single sub-module, fpu_regfile_rdport, implements one registered read port (address range check, optional bypass mux, hold); it is instantiated twice.
REQ-032 The storage is an inferred reg array with no vendor primitives, so it is usable on any target.

Verification
REQ-033 DEPTH=16, WIDTH=32, INIT_VALUE=32'hDEAD_BEEF; pulse RESET, then read all 16 entries on both ports -> every read returns DEADBEEF, and BUSY is high for exactly 16 cycles.
REQ-034 Write 0x1234 to entry 5, then read entry 5 on A and entry 0 on B the next cycle -> one cycle later DOA=0x1234 and DOB=DEADBEEF.
REQ-035 Write 0xAAAA to entry 3 while reading entry 3 on A in the same cycle -> DOA=0xAAAA with FPU_REGFILE_BYPASS_EN, the old value without it; a read on the next cycle returns 0xAAAA in both builds.
REQ-036 DEPTH=12: write 0x55 to address 13, then read address 13 -> DOA=0; the prior contents of entries 0..11 are unchanged.
REQ-037 Assert RESET on sweep cycle 7 -> the sweep restarts at 0, and BUSY stays high for 16 cycles after RESET deasserts.
REQ-038 Hold RDENA=0 for 10 cycles while writing to the entry DOA last read -> DOA stays unchanged throughout.
